// File: rtl/mem_pkg.sv
// Shared command encodings, FSM state type and latency counter sizing for the memory
// responder.
package mem_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Wide enough for the largest legal LATENCY of 15.
  localparam int unsigned LatCntWidth = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } responder_state_t;

endpackage

// File: rtl/memory_array.sv
// Single-port synchronous word RAM with per-byte write enables.
// The read port is registered, so data appears the cycle after the address is presented.
module memory_array #(
  parameter int unsigned AddrWidth = 12,
  parameter string       InitFile  = ""
) (
  input  logic                 clk,
  input  logic [AddrWidth-1:0] addr,
  input  logic                 write_enable,
  input  logic [3:0]           write_strobe,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data
);

  logic [31:0] mem [2**AddrWidth];

  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (write_enable && write_strobe[lane]) begin
        mem[addr][8*lane +: 8] <= write_data[8*lane +: 8];
      end
    end
    read_data <= mem[addr];
  end

endmodule

// File: rtl/memory_responder.sv
// Target side of the core's memory handshake: one request in flight, configurable wait
// states, byte-lane writes and an out-of-window error flag, backed by memory_array.
module memory_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned DEPTH_LOG2   = 12,
  parameter int unsigned LATENCY      = 1,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memory_enable,
  input  logic        memory_command,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_data,
  input  logic [3:0]  memory_write_strobe,
  output logic        memory_ready,
  output logic        memory_valid,
  output logic [31:0] memory_read_data,
  output logic        memory_error
);

  responder_state_t       state_q;
  logic [LatCntWidth-1:0] count_q;
  logic                   ready_q;
  logic                   valid_q;
  logic                   command_q;
  logic [DEPTH_LOG2-1:0]  index_q;
  logic [31:0]            write_data_q;
  logic [3:0]             write_strobe_q;
  logic                   error_q;

  logic [31:0]            offset;
  logic                   out_of_window;
  logic                   accept;
  logic [DEPTH_LOG2-1:0]  ram_addr;
  logic                   ram_write;
  logic [31:0]            ram_read_data;

  assign offset        = memory_address - BASE_ADDRESS;
  assign out_of_window = (memory_address < BASE_ADDRESS) ||
                         ((offset >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign accept        = ready_q && memory_enable;

  // The RAM sees the live request address while idle so a LATENCY of 1 still has the
  // word ready in the RESPOND cycle; afterwards it keeps re-reading the latched index.
  assign ram_addr  = (state_q == IDLE) ? offset[DEPTH_LOG2+1:2] : index_q;
  assign ram_write = reset_n && (state_q == RESPOND) && (command_q == MEM_WRITE) &&
                     !error_q;

  memory_array #(
    .AddrWidth (DEPTH_LOG2),
    .InitFile  (INIT_FILE)
  ) u_memory_array (
    .clk          (clk),
    .addr         (ram_addr),
    .write_enable (ram_write),
    .write_strobe (write_strobe_q),
    .write_data   (write_data_q),
    .read_data    (ram_read_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      count_q        <= '0;
      ready_q        <= 1'b0;
      valid_q        <= 1'b0;
      command_q      <= MEM_READ;
      index_q        <= '0;
      write_data_q   <= '0;
      write_strobe_q <= '0;
      error_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            command_q      <= memory_command;
            index_q        <= offset[DEPTH_LOG2+1:2];
            write_data_q   <= memory_write_data;
            write_strobe_q <= memory_write_strobe;
            error_q        <= out_of_window;
            count_q        <= LatCntWidth'(LATENCY - 1);
            ready_q        <= 1'b0;
            if (LATENCY == 1) begin
              state_q <= RESPOND;
              valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          count_q <= count_q - LatCntWidth'(1);
          if (count_q == LatCntWidth'(1)) begin
            state_q <= RESPOND;
            valid_q <= 1'b1;
          end
        end
        RESPOND: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign memory_ready     = ready_q;
  assign memory_valid     = valid_q;
  assign memory_error     = valid_q && error_q;
  assign memory_read_data = (valid_q && (command_q == MEM_READ) && !error_q) ?
                            ram_read_data : 32'h0;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench: three responders (LATENCY 1, 3, 4) driven by directed and random
// requests, checked against a word-array model of the RAM and the handshake timing rules.
module tb_memory_responder;
  import mem_pkg::*;

  localparam int NumDut = 3;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } pend_t;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  logic        clk;
  logic        rst_n     [NumDut];
  logic        req_en    [NumDut];
  logic        req_cmd   [NumDut];
  logic [31:0] req_addr  [NumDut];
  logic [31:0] req_wdata [NumDut];
  logic [3:0]  req_strb  [NumDut];
  logic        rsp_ready [NumDut];
  logic        rsp_valid [NumDut];
  logic [31:0] rsp_data  [NumDut];
  logic        rsp_err   [NumDut];

  logic [31:0] model [NumDut][4096];
  int total;
  int bad;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    memory_responder #(
      .BASE_ADDRESS (32'h0000_0000),
      .DEPTH_LOG2   (12),
      .LATENCY      (lat_of(g)),
      .INIT_FILE    ("")
    ) u_dut (
      .clk                 (clk),
      .reset_n             (rst_n[g]),
      .memory_enable       (req_en[g]),
      .memory_command      (req_cmd[g]),
      .memory_address      (req_addr[g]),
      .memory_write_data   (req_wdata[g]),
      .memory_write_strobe (req_strb[g]),
      .memory_ready        (rsp_ready[g]),
      .memory_valid        (rsp_valid[g]),
      .memory_read_data    (rsp_data[g]),
      .memory_error        (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: RAM window is 4096 words from address 0; writes merge lanes.
  task automatic predict(input int i, input logic cmd, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] strb,
                         output logic [31:0] exp_data, output logic exp_err);
    int unsigned idx;
    idx      = 32'(addr[13:2]);
    exp_err  = (addr >= 32'h0000_4000);
    exp_data = 32'h0;
    if (!exp_err) begin
      if (cmd == MEM_READ) begin
        exp_data = model[i][idx];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) model[i][idx][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end
  endtask

  // One isolated request; checks latency, response fields and ready recovery.
  task automatic transact(input int i, input logic cmd, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] strb, input string tag);
    logic [31:0] exp_data;
    logic        exp_err;
    int          k;
    k = 0;
    while (rsp_ready[i] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, " ready before"}, 32'(rsp_ready[i]), 32'd1);
    predict(i, cmd, addr, wd, strb, exp_data, exp_err);
    req_en[i]    = 1'b1;
    req_cmd[i]   = cmd;
    req_addr[i]  = addr;
    req_wdata[i] = wd;
    req_strb[i]  = strb;
    @(negedge clk);
    req_en[i]    = 1'b0;
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    req_strb[i]  = 4'($urandom);
    k = 1;
    while (rsp_valid[i] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(lat_of(i)));
    check({tag, " data"}, rsp_data[i], exp_data);
    check({tag, " error"}, 32'(rsp_err[i]), 32'(exp_err));
    check({tag, " ready in valid"}, 32'(rsp_ready[i]), 32'd0);
    @(negedge clk);
    check({tag, " ready after"}, 32'(rsp_ready[i]), 32'd1);
    check({tag, " valid after"}, 32'(rsp_valid[i]), 32'd0);
  endtask

  // Enable held high with fresh random requests every cycle; scoreboard the responses.
  task automatic burst(input int i, input int ncyc);
    pend_t       q[$];
    pend_t       p;
    logic [31:0] exp_data;
    logic        exp_err;
    int          last_acc;
    int          accepts;
    int          responses;
    last_acc  = -1;
    accepts   = 0;
    responses = 0;
    req_en[i] = 1'b1;
    for (int cyc = 0; cyc < ncyc + lat_of(i) + 2; cyc++) begin
      if (rsp_valid[i] === 1'b1) begin
        responses++;
        check($sformatf("b2b%0d ready in valid", i), 32'(rsp_ready[i]), 32'd0);
        if (q.size() == 0) begin
          check($sformatf("b2b%0d spurious valid", i), 32'(rsp_valid[i]), 32'd0);
        end else begin
          p = q.pop_front();
          check($sformatf("b2b%0d due cycle", i), 32'(cyc), 32'(p.due));
          check($sformatf("b2b%0d data", i), rsp_data[i], p.data);
          check($sformatf("b2b%0d error", i), 32'(rsp_err[i]), 32'(p.err));
        end
      end
      if (cyc >= ncyc) req_en[i] = 1'b0;
      req_cmd[i]   = ($urandom_range(0, 2) == 0) ? MEM_WRITE : MEM_READ;
      req_addr[i]  = ($urandom_range(0, 7) == 0) ? 32'h4000 + 4 * $urandom_range(0, 255)
                                                 : 4 * $urandom_range(0, 17);
      req_wdata[i] = $urandom;
      req_strb[i]  = 4'($urandom);
      if (req_en[i] && rsp_ready[i] === 1'b1) begin
        if (last_acc >= 0) begin
          check($sformatf("b2b%0d accept spacing", i), 32'(cyc - last_acc),
                32'(lat_of(i) + 1));
        end
        last_acc = cyc;
        accepts++;
        predict(i, req_cmd[i], req_addr[i], req_wdata[i], req_strb[i], exp_data, exp_err);
        p.data = exp_data;
        p.err  = exp_err;
        p.due  = cyc + lat_of(i);
        q.push_back(p);
      end
      @(negedge clk);
    end
    check($sformatf("b2b%0d responses", i), 32'(responses), 32'(accepts));
    check($sformatf("b2b%0d pending left", i), 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] first_data;
    int          pulses;
    total = 0;
    bad   = 0;
    for (int i = 0; i < NumDut; i++) begin
      rst_n[i]     = 1'b0;
      req_en[i]    = 1'b0;
      req_cmd[i]   = MEM_READ;
      req_addr[i]  = 32'h0;
      req_wdata[i] = 32'h0;
      req_strb[i]  = 4'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NumDut; i++) begin
      check($sformatf("reset%0d ready", i), 32'(rsp_ready[i]), 32'd0);
      check($sformatf("reset%0d valid", i), 32'(rsp_valid[i]), 32'd0);
      check($sformatf("reset%0d data", i), rsp_data[i], 32'h0);
      check($sformatf("reset%0d error", i), 32'(rsp_err[i]), 32'd0);
      rst_n[i] = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < NumDut; i++) begin
      check($sformatf("release%0d ready", i), 32'(rsp_ready[i]), 32'd1);
    end

    for (int i = 0; i < NumDut; i++) begin
      for (int w = 0; w < 18; w++) begin
        transact(i, MEM_WRITE, 32'(4 * w), $urandom, 4'hF, $sformatf("preload%0d", i));
      end
    end

    transact(0, MEM_WRITE, 32'h40, 32'hDEAD_BEEF, 4'hF, "lat1 wr");
    transact(0, MEM_READ, 32'h40, 32'h0, 4'h0, "lat1 rd 0x40");

    transact(1, MEM_WRITE, 32'h44, 32'hFFFF_FFFF, 4'hF, "lat3 fill");
    transact(1, MEM_WRITE, 32'h44, 32'h1122_3344, 4'b0101, "lat3 strobe wr");
    transact(1, MEM_READ, 32'h44, 32'h0, 4'h0, "lat3 strobe rd");

    transact(0, MEM_READ, 32'h4000, 32'h0, 4'h0, "oor rd");
    transact(0, MEM_WRITE, 32'h4000, 32'hCAFE_F00D, 4'hF, "oor wr");
    transact(0, MEM_READ, 32'h0, 32'h0, 4'h0, "oor alias rd");
    transact(0, MEM_WRITE, 32'h3FFC, 32'h0BAD_CAFE, 4'hF, "last word wr");
    transact(0, MEM_READ, 32'h3FFC, 32'h0, 4'h0, "last word rd");
    transact(2, MEM_WRITE, 32'h4, 32'h1234_5678, 4'b0000, "null strobe wr");
    transact(2, MEM_READ, 32'h4, 32'h0, 4'h0, "null strobe rd");

    // A second enable during WAIT must be ignored.
    transact(1, MEM_WRITE, 32'h8, 32'hA5A5_0002, 4'hF, "ign prep2");
    transact(1, MEM_WRITE, 32'hC, 32'h5A5A_0003, 4'hF, "ign prep3");
    req_en[1]   = 1'b1;
    req_cmd[1]  = MEM_READ;
    req_addr[1] = 32'h8;
    @(negedge clk);
    req_addr[1] = 32'hC;
    @(negedge clk);
    req_en[1]   = 1'b0;
    pulses      = 0;
    first_data  = 32'h0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid[1] === 1'b1) begin
        if (pulses == 0) first_data = rsp_data[1];
        pulses++;
      end
      @(negedge clk);
    end
    check("ignored enable pulses", 32'(pulses), 32'd1);
    check("ignored enable data", first_data, model[1][2]);

    burst(0, 40);
    burst(1, 48);
    burst(2, 60);

    // Reset one cycle after accepting a write: nothing may be committed or answered.
    transact(2, MEM_WRITE, 32'h14, 32'h7777_0005, 4'hF, "rst prep");
    req_en[2]    = 1'b1;
    req_cmd[2]   = MEM_WRITE;
    req_addr[2]  = 32'h14;
    req_wdata[2] = 32'h8888_FFFA;
    req_strb[2]  = 4'hF;
    @(negedge clk);
    req_en[2] = 1'b0;
    rst_n[2]  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("mid rst ready c%0d", c), 32'(rsp_ready[2]), 32'd0);
      check($sformatf("mid rst valid c%0d", c), 32'(rsp_valid[2]), 32'd0);
    end
    rst_n[2] = 1'b1;
    @(negedge clk);
    check("post rst ready", 32'(rsp_ready[2]), 32'd1);
    check("post rst valid", 32'(rsp_valid[2]), 32'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid[2] === 1'b1) pulses++;
      @(negedge clk);
    end
    check("post rst stray valid", 32'(pulses), 32'd0);
    transact(2, MEM_READ, 32'h14, 32'h0, 4'h0, "rst word kept");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
